// File: rtl/mem_map_pkg.sv
// Shared address map, state and target encodings for the data-side memory controller.
package mem_map_pkg;

  localparam logic [31:0] ADDR_OUT = 32'h8000_0000;
  localparam logic [31:0] ADDR_CYC = 32'h8000_0004;
  localparam logic [31:0] RD_ERR   = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_OUT,
    TGT_CYC,
    TGT_NONE
  } tgt_e;

  // Word-granular decode: bits [1:0] never take part.
  function automatic tgt_e decode_tgt(logic [31:0] addr);
    if (!addr[31]) begin
      return TGT_RAM;
    end else if (addr[31:2] == ADDR_OUT[31:2]) begin
      return TGT_OUT;
    end else if (addr[31:2] == ADDR_CYC[31:2]) begin
      return TGT_CYC;
    end
    return TGT_NONE;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-to-memory request/response bus; the core is master, mem_ctrl is slave.
interface mem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_data,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_data,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_ram.sv
// Single-port word RAM, synchronous write and registered read (block-RAM style).
module mem_ram #(
  parameter int unsigned RAM_AW = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [RAM_AW-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**RAM_AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Data-side memory controller: decodes core requests to word RAM or MMIO (OUT, CYC)
// and answers with a one-cycle mem_ready pulse after a fixed read latency.
module mem_ctrl
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_AW  = 6,
  parameter int unsigned RD_LAT  = 1,
  parameter logic [15:0] OUT_RST = 16'h0000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_ctrl_if.slave      bus,
  output logic [15:0]    data_out_o
);

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  state_e            state_q;
  tgt_e              tgt_q;
  logic              wr_q;
  logic              ready_q;
  logic [2:0]        lat_q;
  logic [31:0]       rdata_q;
  logic [31:0]       cyc_q;
  logic [15:0]       out_q;
  logic [RAM_AW-1:0] idx_q;

  logic              accept;
  tgt_e              tgt_in;
  logic [RAM_AW-1:0] idx_in;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  always_comb begin
    accept   = (state_q == ST_IDLE) && bus.mem_req && !rst_i;
    tgt_in   = decode_tgt(bus.mem_addr);
    idx_in   = bus.mem_addr[RAM_AW+1:2];
    ram_we   = accept && bus.mem_we && (tgt_in == TGT_RAM);
    // Once busy, the RAM keeps re-reading the latched index so late address changes are ignored.
    ram_addr = (state_q == ST_IDLE) ? idx_in : idx_q;
  end

  mem_ram #(
    .RAM_AW (RAM_AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (bus.mem_data),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tgt_q   <= TGT_NONE;
      wr_q    <= 1'b0;
      ready_q <= 1'b0;
      lat_q   <= 3'd0;
      rdata_q <= 32'h0;
      cyc_q   <= 32'h0;
      out_q   <= OUT_RST;
      idx_q   <= '0;
    end else begin
      cyc_q   <= cyc_q + 32'd1;
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.mem_req) begin
            tgt_q <= tgt_in;
            idx_q <= idx_in;
            wr_q  <= bus.mem_we;
            if (bus.mem_we) begin
              if (tgt_in == TGT_OUT) begin
                out_q <= bus.mem_data[15:0];
              end
              state_q <= ST_RESP;
              ready_q <= 1'b1;
            end else begin
              unique case (tgt_in)
                TGT_OUT:  rdata_q <= {16'h0, out_q};
                TGT_CYC:  rdata_q <= cyc_q;
                TGT_NONE: rdata_q <= RD_ERR;
                default:  rdata_q <= 32'h0;
              endcase
              lat_q <= LAT_INIT;
              if (RD_LAT == 1) begin
                state_q <= ST_RESP;
                ready_q <= 1'b1;
              end else begin
                state_q <= ST_RD_WAIT;
              end
            end
          end
        end
        ST_RD_WAIT: begin
          lat_q <= lat_q - 3'd1;
          if (lat_q == 3'd1) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = (ready_q && !wr_q) ? ((tgt_q == TGT_RAM) ? ram_rdata : rdata_q) : 32'h0;
  assign data_out_o    = out_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: three instances (RD_LAT 1/3/4) share one stimulus driver,
// a select steers requests to one instance at a time.
module tb_mem_ctrl;

  localparam logic [15:0] OUT_RST = 16'h00A5;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  int          sel;

  logic        rdy;
  logic [31:0] rdata;
  logic [15:0] dout;
  logic [15:0] dout1, dout3, dout4;

  int checks;
  int failures;

  mem_ctrl_if if1 ();
  mem_ctrl_if if3 ();
  mem_ctrl_if if4 ();

  assign if1.mem_req  = req && (sel == 1);
  assign if3.mem_req  = req && (sel == 3);
  assign if4.mem_req  = req && (sel == 4);
  assign if1.mem_we   = we;
  assign if3.mem_we   = we;
  assign if4.mem_we   = we;
  assign if1.mem_addr = addr;
  assign if3.mem_addr = addr;
  assign if4.mem_addr = addr;
  assign if1.mem_data = wdata;
  assign if3.mem_data = wdata;
  assign if4.mem_data = wdata;

  mem_ctrl #(.RAM_AW(6), .RD_LAT(1), .OUT_RST(OUT_RST)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .bus(if1), .data_out_o(dout1)
  );
  mem_ctrl #(.RAM_AW(6), .RD_LAT(3), .OUT_RST(OUT_RST)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .bus(if3), .data_out_o(dout3)
  );
  mem_ctrl #(.RAM_AW(6), .RD_LAT(4), .OUT_RST(OUT_RST)) u_lat4 (
    .clk_i(clk), .rst_i(rst), .bus(if4), .data_out_o(dout4)
  );

  always_comb begin
    rdy   = if1.mem_ready;
    rdata = if1.mem_rdata;
    dout  = dout1;
    case (sel)
      3: begin rdy = if3.mem_ready; rdata = if3.mem_rdata; dout = dout3; end
      4: begin rdy = if4.mem_ready; rdata = if4.mem_rdata; dout = dout4; end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge one cycle after the ready pulse.
  task automatic access(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble, output logic [31:0] rd, output int lat,
                        output bit pulse_ok, output bit zero_ok);
    sel = s; we = w; addr = a; wdata = d; req = 1'b1;
    lat = 0; rd = 32'h0; zero_ok = 1'b1; pulse_ok = 1'b0;
    @(posedge clk);
    if (scramble) begin
      #1;
      addr  = 32'h8000_0010;
      we    = ~w;
      wdata = 32'hFFFF_0000;
    end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (rdy) begin
        lat = i;
        rd  = rdata;
        break;
      end else if (rdata != 32'h0) begin
        zero_ok = 1'b0;
      end
    end
    req = 1'b0;
    @(negedge clk);
    pulse_ok = !rdy;
  endtask

  typedef struct {
    int          sel;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] rd, v1, v2, v3;
    int          lat;
    bit          pulse_ok, zero_ok, stray;

    checks = 0; failures = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; sel = 1;

    vecs[0]  = '{1, 1'b1, 32'h0000_000C, 32'h1234_5678, 32'h0,          1, 16'h00A5};
    vecs[1]  = '{1, 1'b0, 32'h0000_000C, 32'h0,          32'h1234_5678, 1, 16'h00A5};
    vecs[2]  = '{1, 1'b1, 32'h8000_0000, 32'hABCD_5A5A, 32'h0,          1, 16'h5A5A};
    vecs[3]  = '{1, 1'b0, 32'h8000_0000, 32'h0,          32'h0000_5A5A, 1, 16'h5A5A};
    vecs[4]  = '{1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,          1, 16'h5A5A};
    vecs[5]  = '{1, 1'b0, 32'h0000_0000, 32'h0,          32'hCAFE_F00D, 1, 16'h5A5A};
    vecs[6]  = '{1, 1'b0, 32'h8000_0010, 32'h0,          32'hDEAD_BEEF, 1, 16'h5A5A};
    vecs[7]  = '{1, 1'b1, 32'h8000_0010, 32'h1111_2222, 32'h0,          1, 16'h5A5A};
    vecs[8]  = '{1, 1'b0, 32'h8000_0003, 32'h0,          32'h0000_5A5A, 1, 16'h5A5A};
    vecs[9]  = '{1, 1'b0, 32'h0000_010C, 32'h0,          32'h1234_5678, 1, 16'h5A5A};
    vecs[10] = '{3, 1'b1, 32'h0000_000C, 32'h8765_4321, 32'h0,          1, 16'h00A5};
    vecs[11] = '{3, 1'b0, 32'h0000_000C, 32'h0,          32'h8765_4321, 3, 16'h00A5};
    vecs[12] = '{4, 1'b1, 32'h8000_0000, 32'h0000_BEEF, 32'h0,          1, 16'hBEEF};
    vecs[13] = '{4, 1'b0, 32'h8000_0000, 32'h0,          32'h0000_BEEF, 4, 16'hBEEF};
    vecs[14] = '{4, 1'b1, 32'h0000_000C, 32'h0BAD_F00D, 32'h0,          1, 16'hBEEF};

    repeat (3) @(negedge clk);
    check("reset_ready", {31'h0, rdy}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_dout", {16'h0, dout}, {16'h0, OUT_RST});
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      access(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].data, 1'b0, rd, lat,
             pulse_ok, zero_ok);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_dout", i), {16'h0, dout}, {16'h0, vecs[i].exp_dout});
      check($sformatf("v%0d_single_pulse", i), {31'h0, pulse_ok}, 32'h1);
      check($sformatf("v%0d_rdata_zero_idle", i), {31'h0, zero_ok}, 32'h1);
    end

    // Address/we changed while the RD_LAT=3 read is pending.
    access(3, 1'b0, 32'h0000_000C, 32'h0, 1'b1, rd, lat, pulse_ok, zero_ok);
    check("scramble_latency", lat, 3);
    check("scramble_rdata", rd, 32'h8765_4321);
    check("scramble_dout", {16'h0, dout}, {16'h0, OUT_RST});

    // Cycle counter: accepts 7 apart, then a write to CYC, then accepts 4 apart.
    access(1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, v1, lat, pulse_ok, zero_ok);
    repeat (5) @(negedge clk);
    access(1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, v2, lat, pulse_ok, zero_ok);
    access(1, 1'b1, 32'h8000_0004, 32'h0000_0000, 1'b0, rd, lat, pulse_ok, zero_ok);
    access(1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, v3, lat, pulse_ok, zero_ok);
    check("cyc_delta_7", v2 - v1, 32'd7);
    check("cyc_delta_after_write", v3 - v2, 32'd4);

    // Reset in the middle of an RD_LAT=4 read.
    sel = 4; we = 1'b0; addr = 32'h0000_000C; req = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'h0, rdy}, 32'h0);
    check("rst_dout", {16'h0, dout}, {16'h0, OUT_RST});
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rdy) stray = 1'b1;
    end
    check("rst_no_stray_ready", {31'h0, stray}, 32'h0);
    access(4, 1'b0, 32'h8000_0004, 32'h0, 1'b0, rd, lat, pulse_ok, zero_ok);
    check("rst_cyc_value", rd, 32'd5);
    access(4, 1'b0, 32'h0000_000C, 32'h0, 1'b0, rd, lat, pulse_ok, zero_ok);
    check("post_rst_latency", lat, 4);
    check("post_rst_ram_kept", rd, 32'h0BAD_F00D);
    check("post_rst_pulse", {31'h0, pulse_ok}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
